// File: rtl/unbiased_rounding.sv
// ============================================================================
// unbiased_rounding -- 2-stage convergent (round-half-even) rounding + saturation
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module unbiased_rounding #(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 16,
  parameter bit IS_SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [WIDTH_IN-1:0]  din,
  output logic [WIDTH_OUT-1:0] dout
);

  localparam int DIFF = WIDTH_IN - WIDTH_OUT;
  localparam logic [WIDTH_OUT-1:0] SAT_MAX_S = {1'b0, {(WIDTH_OUT-1){1'b1}}};
  localparam logic [WIDTH_OUT-1:0] SAT_MIN_S = {1'b1, {(WIDTH_OUT-1){1'b0}}};

  logic                 w_lsb;
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_inc;
  logic [WIDTH_OUT-1:0] r_trunc;
  logic                 r_inc;
  logic [WIDTH_OUT:0]   w_ext;
  logic [WIDTH_OUT:0]   w_sum;
  logic [WIDTH_OUT-1:0] w_sat;

  assign w_lsb   = din[DIFF];
  assign w_guard = din[DIFF-1];

  generate
    if (DIFF > 1) begin : g_sticky_or
      assign w_sticky = |din[DIFF-2:0];
    end else begin : g_sticky_none
      assign w_sticky = 1'b0;
    end
  endgenerate

  // Round up above half, and on an exact half only when the kept part is odd.
  assign w_inc = w_guard & (w_sticky | w_lsb);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trunc <= '0;
      r_inc   <= 1'b0;
    end else if (ena) begin
      r_trunc <= din[WIDTH_IN-1:DIFF];
      r_inc   <= w_inc;
    end
  end

  assign w_ext = {(IS_SIGNED ? r_trunc[WIDTH_OUT-1] : 1'b0), r_trunc};
  assign w_sum = w_ext + {{WIDTH_OUT{1'b0}}, r_inc};

  // One extra sum bit exposes overflow without wrap-around.
  always_comb begin
    w_sat = w_sum[WIDTH_OUT-1:0];
    if (IS_SIGNED) begin
      if (w_sum[WIDTH_OUT] != w_sum[WIDTH_OUT-1])
        w_sat = w_sum[WIDTH_OUT] ? SAT_MIN_S : SAT_MAX_S;
    end else if (w_sum[WIDTH_OUT]) begin
      w_sat = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      dout <= '0;
    else if (ena)
      dout <= w_sat;
  end

endmodule

`default_nettype wire

// File: tb/tb_unbiased_rounding.sv
// ============================================================================
// tb_unbiased_rounding -- directed vectors, control sequences and random sweep
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_unbiased_rounding;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [31:0] din = '0;
  logic [15:0] dout_u;
  logic [15:0] dout_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  unbiased_rounding #(.WIDTH_IN(32), .WIDTH_OUT(16), .IS_SIGNED(1'b0)) u_uns (
    .clk(clk), .rst(rst), .ena(ena), .din(din), .dout(dout_u)
  );

  unbiased_rounding #(.WIDTH_IN(32), .WIDTH_OUT(16), .IS_SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .ena(ena), .din(din), .dout(dout_s)
  );

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference: floor division, then compare the remainder against one half.
  function automatic logic [15:0] ref_round(input logic sgn, input logic [31:0] d);
    longint q, r;
    if (sgn) q = longint'($signed(d)) >>> 16;
    else     q = longint'(d) >> 16;
    r = longint'(d & 32'h0000_FFFF);
    if (r > 32768 || (r == 32768 && (q % 2 != 0))) q = q + 1;
    if (sgn) begin
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
    end else if (q > 65535) begin
      q = 65535;
    end
    return q[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] held_u, held_s;
  logic [31:0] hist[0:299];

  initial begin
    vecs.push_back('{"u_tie_odd",    1'b0, 32'h0001_8000, 16'h0002});
    vecs.push_back('{"u_tie_even",   1'b0, 32'h0002_8000, 16'h0002});
    vecs.push_back('{"u_below_half", 1'b0, 32'h0002_7FFF, 16'h0002});
    vecs.push_back('{"u_above_half", 1'b0, 32'h0002_8001, 16'h0003});
    vecs.push_back('{"u_sat_tie",    1'b0, 32'hFFFF_8000, 16'hFFFF});
    vecs.push_back('{"u_max_below",  1'b0, 32'hFFFF_7FFF, 16'hFFFF});
    vecs.push_back('{"u_zero_tie",   1'b0, 32'h0000_8000, 16'h0000});
    vecs.push_back('{"u_0p75",       1'b0, 32'h0000_C000, 16'h0001});
    vecs.push_back('{"s_m1p5",       1'b1, 32'hFFFE_8000, 16'hFFFE});
    vecs.push_back('{"s_m2p5",       1'b1, 32'hFFFD_8000, 16'hFFFE});
    vecs.push_back('{"s_m0p75",      1'b1, 32'hFFFF_4000, 16'hFFFF});
    vecs.push_back('{"s_min",        1'b1, 32'h8000_0000, 16'h8000});
    vecs.push_back('{"s_sat_tie",    1'b1, 32'h7FFF_8000, 16'h7FFF});
    vecs.push_back('{"s_max_below",  1'b1, 32'h7FFF_7FFF, 16'h7FFF});
    vecs.push_back('{"s_m0p5",       1'b1, 32'hFFFF_8000, 16'h0000});
    vecs.push_back('{"s_p1p5",       1'b1, 32'h0001_8000, 16'h0002});

    // Reset state
    step();
    check("reset_u", dout_u, 16'h0000);
    check("reset_s", dout_s, 16'h0000);
    rst = 1'b0;
    ena = 1'b1;

    // Directed table: each vector given two enabled edges to reach dout
    foreach (vecs[i]) begin
      din = vecs[i].din;
      step();
      step();
      check(vecs[i].name, vecs[i].sgn ? dout_s : dout_u, vecs[i].exp);
    end

    // Enable hold: dout frozen while din wanders with ena low
    din = 32'h0005_8000;
    step();
    step();
    held_u = dout_u;
    held_s = dout_s;
    check("ena_setup", dout_u, 16'h0006);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din = 32'h1234_0000 + 32'(k) * 32'h0011_1111;
      step();
      check("ena_hold_u", dout_u, held_u);
      check("ena_hold_s", dout_s, held_s);
    end
    ena = 1'b1;
    din = 32'h0009_C000;
    step();
    check("ena_resume_edge1", dout_u, 16'h0006);
    step();
    check("ena_resume_edge2", dout_u, 16'h000A);

    // Reset mid-stream, also with ena low to show reset wins
    din = 32'h0100_0000;
    step();
    din = 32'h0200_0000;
    step();
    rst = 1'b1;
    ena = 1'b0;
    step();
    check("rst_mid_u", dout_u, 16'h0000);
    check("rst_mid_s", dout_s, 16'h0000);
    rst = 1'b0;
    ena = 1'b1;
    din = 32'h0003_0000;
    step();
    check("rst_flush_edge1", dout_u, 16'h0000);
    step();
    check("rst_flush_edge2", dout_u, 16'h0003);

    // Back-to-back random sweep, biased towards ties and saturation
    for (int i = 0; i < 300; i++) begin
      logic [31:0] v;
      v = $urandom;
      if (i % 4 == 0) v[15:0] = 16'h8000;
      if (i % 7 == 0) v[31:17] = (i % 2 == 0) ? 15'h7FFF : 15'h3FFF;
      hist[i] = v;
      din = v;
      step();
      if (i >= 1) begin
        check("sweep_u", dout_u, ref_round(1'b0, hist[i-1]));
        check("sweep_s", dout_s, ref_round(1'b1, hist[i-1]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
